// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg
//   Shared constants for the port-B arbiter of the 16-bit dual-port block RAM:
//   default RAM geometry, requester indices and the arbiter state encoding.
//   State encoding (3 bits):
//     ST_IDLE    - no access on port B this cycle
//     ST_ISSUE0  - m0's access is on port B this cycle
//     ST_ISSUE1  - m1's access is on port B this cycle
//     ST_LOCKED0 - port B idle, m0 holds the lock (DPRAM_ARB_LOCK_EN builds only)
//     ST_LOCKED1 - port B idle, m1 holds the lock (DPRAM_ARB_LOCK_EN builds only)
package dpram_arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 13;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 3'd0;
  localparam arb_state_t ST_ISSUE0  = 3'd1;
  localparam arb_state_t ST_ISSUE1  = 3'd2;
  localparam arb_state_t ST_LOCKED0 = 3'd3;
  localparam arb_state_t ST_LOCKED1 = 3'd4;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin pick. When both requesters are
//   eligible the one that did not win last time is chosen.
//   Ports:
//     eligible_i[1:0] - per-requester eligibility (bit 0 = m0, bit 1 = m1)
//     last_grant_i    - index of the previously granted requester
//     grant_valid_o   - at least one requester is eligible
//     grant_idx_o     - index of the chosen requester (valid with grant_valid_o)
module rr_arb2
  import dpram_arb_pkg::*;
(
  input  logic [1:0] eligible_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_valid_o = |eligible_i;
    grant_idx_o   = REQ_M0;
    if (eligible_i == 2'b11) begin
      grant_idx_o = ~last_grant_i;
    end else if (eligible_i[1]) begin
      grant_idx_o = REQ_M1;
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
//   Shares port B (read/write) of the dual-port block RAM between the CPU data
//   bus (m0) and the DMA/debug loader (m1). Port A is not handled here.
//
//   Handshake: a requester raises mX_req with mX_we/mX_addr/mX_wdata and holds
//   them stable until the cycle in which mX_ack is high. The access is on the
//   RAM port during that ack cycle. For reads, mX_rvalid pulses the following
//   cycle with mX_rdata taken straight from ram_rdata; mX_rdata holds its last
//   value otherwise. A new request may be presented the cycle after ack. A
//   requester is ignored at the edge that closes its own ack cycle, so a lone
//   requester gets one access every two cycles while two requesters alternate
//   every cycle.
//
//   Ports:
//     clk, rst_n              - clock, synchronous active-low reset
//     mX_req/we/addr/wdata    - requester X access (X = 0, 1)
//     mX_ack                  - one-cycle accept pulse, coincides with the RAM access
//     mX_rdata/mX_rvalid      - read return, one cycle after ack
//     mX_lock                 - (DPRAM_ARB_LOCK_EN only) keep the grant while high
//     ram_ce/we/addr/wdata    - port B controls
//     ram_rdata               - port B read data, one cycle after the access
//
//   Build option DPRAM_ARB_LOCK_EN: adds mX_lock. A requester granted with
//   lock=1 becomes the lock owner; while the owner keeps lock=1 only it can be
//   granted. The lock is released at the first edge that samples lock=0.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
`ifdef DPRAM_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [1:0]        rd_pend_q, rd_pend_d;   // read issued last cycle, per requester
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic [1:0] ack_now;
  logic [1:0] req_vec;
  logic [1:0] eligible;
  logic       grant_valid;
  logic       grant_idx;

  assign ack_now = {state_q == ST_ISSUE1, state_q == ST_ISSUE0};
  assign req_vec = {m1_req, m0_req};

`ifdef DPRAM_ARB_LOCK_EN
  logic       lock_act_q, lock_act_d;
  logic       lock_idx_q, lock_idx_d;
  logic [1:0] lock_vec;
  logic       lock_hold;

  assign lock_vec  = {m1_lock, m0_lock};
  // Lock survives this edge only if the owner is still asserting it.
  assign lock_hold = lock_act_q & lock_vec[lock_idx_q];

  always_comb begin
    eligible = req_vec & ~ack_now;
    if (lock_hold) begin
      eligible = eligible & (lock_idx_q ? 2'b10 : 2'b01);
    end
  end
`else
  // A requester in its ack cycle is still showing the request just served.
  assign eligible = req_vec & ~ack_now;
`endif

  rr_arb2 u_rr_arb2 (
    .eligible_i    (eligible),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_comb begin
    state_d      = ST_IDLE;
    last_grant_d = last_grant_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    // ram_we_q belongs to the access currently on the port.
    rd_pend_d    = ack_now & {2{~ram_we_q}};
    m0_rdata_d   = rd_pend_q[0] ? ram_rdata : m0_rdata_q;
    m1_rdata_d   = rd_pend_q[1] ? ram_rdata : m1_rdata_q;
`ifdef DPRAM_ARB_LOCK_EN
    lock_act_d   = lock_hold;
    lock_idx_d   = lock_idx_q;
`endif

    if (grant_valid) begin
      last_grant_d = grant_idx;
      if (grant_idx == REQ_M1) begin
        state_d     = ST_ISSUE1;
        ram_we_d    = m1_we;
        ram_addr_d  = m1_addr;
        ram_wdata_d = m1_wdata;
      end else begin
        state_d     = ST_ISSUE0;
        ram_we_d    = m0_we;
        ram_addr_d  = m0_addr;
        ram_wdata_d = m0_wdata;
      end
`ifdef DPRAM_ARB_LOCK_EN
      if (lock_vec[grant_idx]) begin
        lock_act_d = 1'b1;
        lock_idx_d = grant_idx;
      end
`endif
    end

`ifdef DPRAM_ARB_LOCK_EN
    if (!grant_valid && lock_act_d) begin
      state_d = lock_idx_d ? ST_LOCKED1 : ST_LOCKED0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_M1;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rd_pend_q    <= 2'b00;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
`ifdef DPRAM_ARB_LOCK_EN
      lock_act_q   <= 1'b0;
      lock_idx_q   <= REQ_M0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rd_pend_q    <= rd_pend_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
`ifdef DPRAM_ARB_LOCK_EN
      lock_act_q   <= lock_act_d;
      lock_idx_q   <= lock_idx_d;
`endif
    end
  end

  assign m0_ack    = ack_now[0];
  assign m1_ack    = ack_now[1];
  assign m0_rvalid = rd_pend_q[0];
  assign m1_rvalid = rd_pend_q[1];
  assign m0_rdata  = m0_rdata_d;
  assign m1_rdata  = m1_rdata_d;
  assign ram_ce    = |ack_now;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter
//   Directed scenarios followed by a randomized phase. A behavioural RAM sits
//   on port B; a transaction-level reference (grant rule, shadow memory,
//   expected ack/rvalid/rdata per cycle) predicts every output each cycle.
module tb_dpram_port_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]    req_v;
  logic [1:0]    we_v;
  logic [AW-1:0] addr_v [2];
  logic [DW-1:0] wdata_v [2];
`ifdef DPRAM_ARB_LOCK_EN
  logic [1:0]    lock_v;
`endif
  logic          m0_ack, m1_ack, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_ce, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  dpram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (req_v[0]),
    .m0_we     (we_v[0]),
    .m0_addr   (addr_v[0]),
    .m0_wdata  (wdata_v[0]),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m0_rvalid (m0_rvalid),
    .m1_req    (req_v[1]),
    .m1_we     (we_v[1]),
    .m1_addr   (addr_v[1]),
    .m1_wdata  (wdata_v[1]),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .m1_rvalid (m1_rvalid),
`ifdef DPRAM_ARB_LOCK_EN
    .m0_lock   (lock_v[0]),
    .m1_lock   (lock_v[1]),
`endif
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // ---------------- port B RAM (registered address) ----------------
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 13'h0005) return 16'hBEEF;
    return {a, 3'b011} ^ 16'h5A5A;
  endfunction

  logic [DW-1:0] ram_mem [DEPTH];
  bit            ram_written [DEPTH];

  always @(posedge clk) begin
    if (ram_ce) begin
      ram_rdata <= ram_written[ram_addr] ? ram_mem[ram_addr] : init_word(ram_addr);
      if (ram_we) begin
        ram_mem[ram_addr]     <= ram_wdata;
        ram_written[ram_addr] <= 1'b1;
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] shadow [DEPTH];
  int            n_vec;
  int            n_miss;
  bit            exp_ack [2];
  bit            exp_rv [2];
  bit            rd_known [2];
  logic [DW-1:0] exp_rdata [2];
  int            last_g;
  int            acc_idx;          // requester whose access is on the port, -1 if none
  bit            acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [AW-1:0] exp_raddr;
  logic [DW-1:0] exp_rwdata;
  bit            done [2];
`ifdef DPRAM_ARB_LOCK_EN
  bit            lk_act;
  int            lk_idx;
`endif

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_ack[i]  = 1'b0;
      exp_rv[i]   = 1'b0;
      rd_known[i] = 1'b0;
    end
    last_g     = 1;
    acc_idx    = -1;
    exp_raddr  = '0;
    exp_rwdata = '0;
`ifdef DPRAM_ARB_LOCK_EN
    lk_act = 1'b0;
    lk_idx = 0;
`endif
  endtask

  // Predict the edge, advance one clock, compare every output.
  task automatic step();
    bit            e [2];
    bit            nrv [2];
    logic [DW-1:0] nrd;
    int            g;
`ifdef DPRAM_ARB_LOCK_EN
    bit            lock_hold;
`endif
    nrv[0] = 1'b0;
    nrv[1] = 1'b0;
    nrd    = '0;
    // The RAM completes the current access whether or not reset is asserted.
    if (acc_idx >= 0) begin
      if (acc_we) shadow[acc_addr] = acc_wdata;
      else begin
        nrv[acc_idx] = 1'b1;
        nrd          = shadow[acc_addr];
      end
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) e[i] = req_v[i] && !exp_ack[i];
`ifdef DPRAM_ARB_LOCK_EN
      lock_hold = lk_act && lock_v[lk_idx];
      if (lock_hold) e[1 - lk_idx] = 1'b0;
`endif
      if (e[0] && e[1]) g = 1 - last_g;
      else if (e[0])    g = 0;
      else if (e[1])    g = 1;
      else              g = -1;
`ifdef DPRAM_ARB_LOCK_EN
      if (g >= 0 && lock_v[g]) begin
        lk_act = 1'b1;
        lk_idx = g;
      end else if (!lock_hold) begin
        lk_act = 1'b0;
      end
`endif
      for (int i = 0; i < 2; i++) begin
        exp_ack[i] = (g == i);
        exp_rv[i]  = nrv[i];
        if (nrv[i]) begin
          exp_rdata[i] = nrd;
          rd_known[i]  = 1'b1;
        end
      end
      acc_idx = g;
      if (g >= 0) begin
        last_g     = g;
        acc_we     = we_v[g];
        acc_addr   = addr_v[g];
        acc_wdata  = wdata_v[g];
        exp_raddr  = acc_addr;
        exp_rwdata = acc_wdata;
      end
    end
    @(posedge clk);
    #1;
    check("m0_ack",    32'(m0_ack),    32'(exp_ack[0]));
    check("m1_ack",    32'(m1_ack),    32'(exp_ack[1]));
    check("ram_ce",    32'(ram_ce),    32'(exp_ack[0] | exp_ack[1]));
    check("ram_we",    32'(ram_we),    32'(acc_idx >= 0 && acc_we));
    check("ram_addr",  32'(ram_addr),  32'(exp_raddr));
    check("ram_wdata", 32'(ram_wdata), 32'(exp_rwdata));
    check("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0]));
    check("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1]));
    if (rd_known[0]) check("m0_rdata", 32'(m0_rdata), 32'(exp_rdata[0]));
    if (rd_known[1]) check("m1_rdata", 32'(m1_rdata), 32'(exp_rdata[1]));
  endtask

  // ---------------- random driver ----------------
  function automatic logic [AW-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 7);
    if ($urandom_range(0, 1) == 1) return 13'(DEPTH - 1 - r);
    return 13'(r);
  endfunction

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      if (exp_ack[i]) begin
        done[i] = 1'b1;            // hold through the ack cycle
      end else if (!req_v[i] || done[i]) begin
        done[i]    = 1'b0;
        req_v[i]   = ($urandom_range(0, 9) < 7);
        we_v[i]    = 1'($urandom_range(0, 1));
        addr_v[i]  = pick_addr();
        wdata_v[i] = 16'($urandom);
`ifdef DPRAM_ARB_LOCK_EN
        lock_v[i]  = ($urandom_range(0, 4) == 0);
`endif
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  int n0, n1, n_ack;
  logic prev_ack;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    for (int a = 0; a < DEPTH; a++) shadow[a] = init_word(13'(a));
    model_reset();
    rst_n = 1'b0;
    req_v = 2'b00;
    we_v  = 2'b00;
`ifdef DPRAM_ARB_LOCK_EN
    lock_v = 2'b00;
`endif
    for (int i = 0; i < 2; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
      done[i]    = 1'b0;
    end

    // reset state
    step();
    step();
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_ce",   32'(ram_ce),   32'd0);
    rst_n = 1'b1;

    // read after reset: preloaded word 0x0005
    addr_v[0] = 13'h0005;
    req_v[0]  = 1'b1;
    step();
    check("t1_ack", 32'(m0_ack), 32'd1);
    step();
    check("t1_rvalid", 32'(m0_rvalid), 32'd1);
    check("t1_rdata",  32'(m0_rdata),  32'hBEEF);
    check("t1_m1_quiet", 32'(m1_ack | m1_rvalid), 32'd0);
    req_v[0] = 1'b0;
    step();
    check("t1_rdata_hold", 32'(m0_rdata), 32'hBEEF);

    // write then read at the top address
    req_v[1]   = 1'b1;
    we_v[1]    = 1'b1;
    addr_v[1]  = 13'h1FFF;
    wdata_v[1] = 16'h1234;
    step();
    check("t2_wr_ack", 32'(m1_ack), 32'd1);
    check("t2_wr_we",  32'(ram_we), 32'd1);
    step();
    we_v[1] = 1'b0;
    step();
    check("t2_rd_ack", 32'(m1_ack), 32'd1);
    step();
    check("t2_rdata",  32'(m1_rdata),  32'h1234);
    check("t2_rvalid", 32'(m1_rvalid), 32'd1);
    req_v[1] = 1'b0;
    step();

    // contention right after reset: m0 first, then strict alternation
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    addr_v[0] = 13'h0010;
    addr_v[1] = 13'h0011;
    we_v      = 2'b00;
    req_v     = 2'b11;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t3_m0_ack", 32'(m0_ack), 32'(k % 2 == 0));
      check("t3_m1_ack", 32'(m1_ack), 32'(k % 2 == 1));
      check("t3_ce",     32'(ram_ce), 32'd1);
    end
    step();
    req_v = 2'b00;
    step();
    step();

    // single requester holding req across 4 writes
    req_v[0]   = 1'b1;
    we_v[0]    = 1'b1;
    addr_v[0]  = 13'h0100;
    wdata_v[0] = 16'hA000;
    n_ack      = 0;
    prev_ack   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (m0_ack) begin
        n_ack++;
        check("t4_spacing", 32'(prev_ack), 32'd0);
      end
      check("t4_m0_ack", 32'(m0_ack), 32'(k % 2 == 0));
      prev_ack = m0_ack;
      if (k % 2 == 1) begin
        addr_v[0]  = addr_v[0] + 13'd1;
        wdata_v[0] = wdata_v[0] + 16'd1;
      end
    end
    check("t4_count", 32'(n_ack), 32'd4);
    req_v[0] = 1'b0;
    step();
    step();

    // reset in the ack cycle of an m1 read
    req_v[1]  = 1'b1;
    we_v[1]   = 1'b0;
    addr_v[1] = 13'h0020;
    step();
    check("t5_ack", 32'(m1_ack), 32'd1);
    rst_n    = 1'b0;
    req_v[1] = 1'b0;
    step();
    check("t5_no_rvalid", 32'(m1_rvalid), 32'd0);
    check("t5_ce",        32'(ram_ce),    32'd0);
    check("t5_addr",      32'(ram_addr),  32'd0);
    check("t5_wdata",     32'(ram_wdata), 32'd0);
    rst_n = 1'b1;
    we_v  = 2'b00;
    req_v = 2'b11;
    step();
    check("t5_tie_m0", 32'(m0_ack), 32'd1);
    check("t5_tie_m1", 32'(m1_ack), 32'd0);
    step();
    req_v = 2'b00;
    step();
    step();

`ifdef DPRAM_ARB_LOCK_EN
    // m1 holds the lock for 3 accesses while m0 waits
    req_v[1]  = 1'b1;
    lock_v[1] = 1'b1;
    we_v[1]   = 1'b0;
    addr_v[1] = 13'h0030;
    step();
    check("t6_m1_first", 32'(m1_ack), 32'd1);
    req_v[0]  = 1'b1;
    we_v[0]   = 1'b0;
    addr_v[0] = 13'h0031;
    n0 = 0;
    n1 = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (m0_ack) n0++;
      if (m1_ack) n1++;
    end
    check("t6_m1_acks",    32'(n1), 32'd3);
    check("t6_m0_starved", 32'(n0), 32'd0);
    step();
    check("t6_m0_wait", 32'(m0_ack), 32'd0);
    lock_v[1] = 1'b0;
    req_v[1]  = 1'b0;
    step();
    check("t6_m0_after_unlock", 32'(m0_ack), 32'd1);
    step();
    req_v[0] = 1'b0;
    step();
    step();
`endif

    // randomized traffic with occasional resets
    done[0] = 1'b0;
    done[1] = 1'b0;
    for (int c = 0; c < 800; c++) begin
      drive_random();
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
